// File: rtl/drlp_dma_pkg.sv
// Shared request/opcode types for the DRLP DMA to manycore mesh bridge.
package drlp_dma_pkg;

  localparam int drlp_addr_w_c  = 32;
  localparam int drlp_data_w_c  = 32;
  localparam int drlp_op_ex_w_c = drlp_data_w_c >> 3;
  localparam logic [drlp_op_ex_w_c-1:0] drlp_op_ex_ones_c = {drlp_op_ex_w_c{1'b1}};

  typedef enum logic [1:0] {
    ePacketOp_remote_load  = 2'd0,
    ePacketOp_remote_store = 2'd1
  } drlp_dma_op_e;

  typedef struct packed {
    logic                     we;
    logic [drlp_addr_w_c-1:0] addr;
    logic [drlp_data_w_c-1:0] data;
  } dma_req_s;

endpackage

// File: rtl/drlp_dma_req_fifo.sv
// Circular request queue with two ordered write ports (store slot first) and one read port.
module drlp_dma_req_fifo
  import drlp_dma_pkg::*;
#(
  parameter int els_p = 4,
  localparam int ptr_w_lp = $clog2(els_p),
  localparam int cnt_w_lp = $clog2(els_p + 1)
)(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                w0_v_i,
  input  dma_req_s            w0_req_i,
  input  logic                w1_v_i,
  input  dma_req_s            w1_req_i,
  input  logic                deq_i,
  output dma_req_s            head_o,
  output logic [cnt_w_lp-1:0] count_o,
  output logic [cnt_w_lp-1:0] count_next_o
);

  dma_req_s            mem_r [els_p];
  logic [ptr_w_lp-1:0] rd_ptr_r;
  logic [ptr_w_lp-1:0] wr_ptr_r;
  logic [ptr_w_lp-1:0] w1_ptr_s;
  logic [cnt_w_lp-1:0] count_r;
  logic [1:0]          n_enq_s;

  // Second write lands behind the first when both ports fire together.
  always_comb begin
    n_enq_s      = {1'b0, w0_v_i} + {1'b0, w1_v_i};
    w1_ptr_s     = w0_v_i ? (wr_ptr_r + ptr_w_lp'(1)) : wr_ptr_r;
    count_next_o = count_r + cnt_w_lp'(n_enq_s) - cnt_w_lp'(deq_i);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      rd_ptr_r <= rd_ptr_r + ptr_w_lp'(deq_i);
      wr_ptr_r <= wr_ptr_r + ptr_w_lp'(n_enq_s);
      count_r  <= count_next_o;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i) begin
    if (w0_v_i) mem_r[wr_ptr_r] <= w0_req_i;
    if (w1_v_i) mem_r[w1_ptr_s] <= w1_req_i;
  end

  assign head_o  = mem_r[rd_ptr_r];
  assign count_o = count_r;

endmodule

// File: rtl/drlp_mesh_dma_bridge.sv
// Turns queued DRLP DMA reads/writes into manycore remote load/store packets and returns load data in order.
module drlp_mesh_dma_bridge
  import drlp_dma_pkg::*;
#(
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 32,
  parameter int fifo_els_p     = 4,
  parameter int max_loads_p    = 8,
  localparam int credit_w_lp     = $clog2(16 + 1),
  localparam int op_ex_w_lp      = data_width_p >> 3,
  localparam int packet_width_lp = addr_width_p + 2 + op_ex_w_lp + data_width_p
                                   + 2 * x_cord_width_p + 2 * y_cord_width_p
)(
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       dma_wr_en_i,
  input  logic [addr_width_p-1:0]    dma_wr_addr_i,
  input  logic [data_width_p-1:0]    dma_wr_data_i,
  input  logic                       dma_rd_en_i,
  input  logic [addr_width_p-1:0]    dma_rd_addr_i,
  output logic                       dma_req_ready_o,
  output logic [data_width_p-1:0]    dma_rd_data_o,
  output logic                       dma_rd_valid_o,
  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,
  input  logic [x_cord_width_p-1:0]  dest_x_i,
  input  logic [y_cord_width_p-1:0]  dest_y_i,
  output logic                       out_v_o,
  output logic [packet_width_lp-1:0] out_packet_o,
  input  logic                       out_ready_i,
  input  logic [credit_w_lp-1:0]     out_credits_i,
  input  logic                       returned_v_i,
  input  logic [data_width_p-1:0]    returned_data_i,
  output logic                       idle_o,
  output logic                       err_o
);

  localparam int cnt_w_lp  = $clog2(fifo_els_p + 1);
  localparam int load_w_lp = $clog2(max_loads_p + 1);

  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    drlp_dma_op_e              op;
    logic [op_ex_w_lp-1:0]     op_ex;
    logic [data_width_p-1:0]   data;
    logic [y_cord_width_p-1:0] src_y_cord;
    logic [x_cord_width_p-1:0] src_x_cord;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } bsg_manycore_packet_s;

  dma_req_s             head_s, w0_req_s, w1_req_s;
  logic [cnt_w_lp-1:0]  count_s, count_next_s;
  logic [load_w_lp-1:0] load_cnt_r, load_cnt_next_s;
  logic                 w0_v_s, w1_v_s, drop_s, deq_s;
  logic                 launch_load_s, ret_ok_s, bad_ret_s;
  logic                 ready_r, idle_r, err_r, rd_valid_r;
  logic [data_width_p-1:0] rd_data_r;
  bsg_manycore_packet_s pkt_s;

  // Requests are only taken while the registered ready promises two free slots.
  always_comb begin
    w0_v_s   = dma_wr_en_i & ready_r;
    w1_v_s   = dma_rd_en_i & ready_r;
    drop_s   = (dma_wr_en_i | dma_rd_en_i) & ~ready_r;
    w0_req_s = '{we: 1'b1, addr: drlp_addr_w_c'(dma_wr_addr_i), data: drlp_data_w_c'(dma_wr_data_i)};
    w1_req_s = '{we: 1'b0, addr: drlp_addr_w_c'(dma_rd_addr_i), data: '0};
  end

  drlp_dma_req_fifo #(.els_p(fifo_els_p)) req_fifo (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .w0_v_i       (w0_v_s),
    .w0_req_i     (w0_req_s),
    .w1_v_i       (w1_v_s),
    .w1_req_i     (w1_req_s),
    .deq_i        (deq_s),
    .head_o       (head_s),
    .count_o      (count_s),
    .count_next_o (count_next_s)
  );

  // Launch gate and outstanding-load bookkeeping; a return with nothing outstanding is rejected.
  always_comb begin
    out_v_o       = (count_s != '0) && (out_credits_i != '0)
                    && (head_s.we || (load_cnt_r < load_w_lp'(max_loads_p)));
    deq_s         = out_v_o & out_ready_i;
    launch_load_s = deq_s & ~head_s.we;
    ret_ok_s      = returned_v_i & (load_cnt_r != '0);
    bad_ret_s     = returned_v_i & (load_cnt_r == '0);
    case ({launch_load_s, ret_ok_s})
      2'b10:   load_cnt_next_s = load_cnt_r + load_w_lp'(1);
      2'b01:   load_cnt_next_s = load_cnt_r - load_w_lp'(1);
      default: load_cnt_next_s = load_cnt_r;
    endcase
  end

  // Packet formed from the queue head.
  always_comb begin
    pkt_s.addr       = head_s.addr[addr_width_p-1:0];
    pkt_s.op         = head_s.we ? ePacketOp_remote_store : ePacketOp_remote_load;
    pkt_s.op_ex      = op_ex_w_lp'(drlp_op_ex_ones_c);
    pkt_s.data       = head_s.data[data_width_p-1:0];
    pkt_s.src_y_cord = my_y_i;
    pkt_s.src_x_cord = my_x_i;
    pkt_s.y_cord     = dest_y_i;
    pkt_s.x_cord     = dest_x_i;
  end

  // Registered status, return path and sticky error.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      load_cnt_r <= '0;
      ready_r    <= 1'b0;
      idle_r     <= 1'b1;
      err_r      <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      load_cnt_r <= load_cnt_next_s;
      ready_r    <= (count_next_s <= cnt_w_lp'(fifo_els_p - 2));
      idle_r     <= (count_next_s == '0) && (load_cnt_next_s == '0);
      err_r      <= err_r | drop_s | bad_ret_s;
      rd_valid_r <= ret_ok_s;
      if (ret_ok_s) rd_data_r <= returned_data_i;
    end
  end

  assign out_packet_o    = pkt_s;
  assign dma_req_ready_o = ready_r;
  assign idle_o          = idle_r;
  assign err_o           = err_r;
  assign dma_rd_valid_o  = rd_valid_r;
  assign dma_rd_data_o   = rd_data_r;

endmodule

// File: tb/tb_drlp_mesh_dma_bridge.sv
// Directed and randomized checks of drlp_mesh_dma_bridge against an in-order request/return model.
module tb_drlp_mesh_dma_bridge;

  localparam int XW = 4;
  localparam int YW = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int ML = 2;
  localparam int PW = AW + 2 + (DW >> 3) + DW + 2 * XW + 2 * YW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    op;
    logic [3:0]    op_ex;
    logic [DW-1:0] data;
    logic [YW-1:0] src_y;
    logic [XW-1:0] src_x;
    logic [YW-1:0] dst_y;
    logic [XW-1:0] dst_x;
  } pkt_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic clk = 1'b0;
  logic reset_i;
  logic wr_en, rd_en, req_ready, rd_valid, out_v, out_ready, ret_v, idle, err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data, ret_data;
  logic [XW-1:0] my_x, dest_x;
  logic [YW-1:0] my_y, dest_y;
  logic [PW-1:0] out_packet;
  logic [4:0]    credits;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  req_t          pkt_q[$];
  logic [DW-1:0] rd_q[$];
  int            viol = 0;
  int            ld_launch_m = 0;
  int            rd_seen_m = 0;

  int   pkt_base = 0;
  int   rd_base = 0;
  int   ld_base = 0;
  int   rdc_base = 0;
  logic rnd_phase = 1'b0;

  req_t          exp_pkt[$];
  logic [DW-1:0] exp_rd[$];
  int            due_q[$];
  int            scan;
  int            r;
  req_t          e;
  pkt_t          chk_p;
  pkt_t          mon_p;

  always #5 clk = ~clk;

  drlp_mesh_dma_bridge #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW), .addr_width_p(AW),
    .fifo_els_p(4), .max_loads_p(ML)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .dma_wr_en_i(wr_en), .dma_wr_addr_i(wr_addr), .dma_wr_data_i(wr_data),
    .dma_rd_en_i(rd_en), .dma_rd_addr_i(rd_addr),
    .dma_req_ready_o(req_ready), .dma_rd_data_o(rd_data), .dma_rd_valid_o(rd_valid),
    .my_x_i(my_x), .my_y_i(my_y), .dest_x_i(dest_x), .dest_y_i(dest_y),
    .out_v_o(out_v), .out_packet_o(out_packet), .out_ready_i(out_ready), .out_credits_i(credits),
    .returned_v_i(ret_v), .returned_data_i(ret_data), .idle_o(idle), .err_o(err)
  );

  // Endpoint-side observer: records accepted packets and load returns, flags rule breaks.
  always @(negedge clk) begin
    mon_p = out_packet;
    if (rd_valid) begin
      rd_q.push_back(rd_data);
      rd_seen_m++;
    end
    if (out_v && credits == 5'd0) viol++;
    if (rnd_phase && out_v && mon_p.op == 2'd0 && ((ld_launch_m - ld_base) - (rd_seen_m - rdc_base)) >= ML) viol++;
    if (out_v && out_ready) begin
      if (mon_p.op_ex !== 4'hF || mon_p.op > 2'd1 || mon_p.src_x !== my_x || mon_p.src_y !== my_y
          || mon_p.dst_x !== dest_x || mon_p.dst_y !== dest_y) viol++;
      pkt_q.push_back('{we: (mon_p.op == 2'd1), addr: mon_p.addr, data: mon_p.data});
      if (mon_p.op == 2'd0) ld_launch_m++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int npk();
    return pkt_q.size() - pkt_base;
  endfunction

  function automatic req_t get_pkt(input int k);
    if (pkt_base + k < pkt_q.size()) return pkt_q[pkt_base + k];
    else return '0;
  endfunction

  task automatic wait_pkts(input int n, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (npk() >= n) break;
      tick();
    end
    check(tag, npk(), n);
  endtask

  task automatic return_one(input logic [DW-1:0] d, input string tag);
    ret_v = 1'b1;
    ret_data = d;
    tick();
    ret_v = 1'b0;
    check({tag, "_rdv"}, rd_valid, 1'b1);
    check({tag, "_rdd"}, rd_data, d);
    tick();
  endtask

  task automatic clear_reqs();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; wr_en = 1'b0; rd_en = 1'b0; ret_v = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; ret_data = '0;
    my_x = 4'h2; my_y = 4'h3; dest_x = 4'h5; dest_y = 4'h6;
    out_ready = 1'b1; credits = 5'd16;
    repeat (3) tick();
    check("rst_ready", req_ready, 1'b0);
    check("rst_outv", out_v, 1'b0);
    check("rst_rdv", rd_valid, 1'b0);
    check("rst_rdd", rd_data, 32'h0);
    check("rst_err", err, 1'b0);
    reset_i = 1'b0;
    tick();
    check("post_rst_idle", idle, 1'b1);
    check("post_rst_ready", req_ready, 1'b1);

    // single store
    pkt_base = pkt_q.size();
    wr_en = 1'b1; wr_addr = 32'h5; wr_data = 32'hDEADBEEF;
    check("t1_no_same_cycle_launch", out_v, 1'b0);
    tick();
    clear_reqs();
    chk_p = out_packet;
    check("t1_outv", out_v, 1'b1);
    check("t1_op", chk_p.op, 2'd1);
    check("t1_opex", chk_p.op_ex, 4'hF);
    check("t1_addr", chk_p.addr, 32'h5);
    check("t1_data", chk_p.data, 32'hDEADBEEF);
    check("t1_src", {chk_p.src_y, chk_p.src_x}, 8'h32);
    check("t1_dst", {chk_p.dst_y, chk_p.dst_x}, 8'h65);
    tick();
    check("t1_count", npk(), 1);
    tick();
    check("t1_idle", idle, 1'b1);
    check("t1_outv_low", out_v, 1'b0);

    // single load and its return
    rd_en = 1'b1; rd_addr = 32'h3;
    tick();
    clear_reqs();
    chk_p = out_packet;
    check("t2_outv", out_v, 1'b1);
    check("t2_op", chk_p.op, 2'd0);
    check("t2_addr", chk_p.addr, 32'h3);
    check("t2_data", chk_p.data, 32'h0);
    repeat (5) tick();
    check("t2_busy", idle, 1'b0);
    check("t2_no_early_rdv", rd_valid, 1'b0);
    ret_v = 1'b1; ret_data = 32'h1234;
    tick();
    ret_v = 1'b0;
    check("t2_rdv", rd_valid, 1'b1);
    check("t2_rdd", rd_data, 32'h1234);
    tick();
    check("t2_rdv_pulse", rd_valid, 1'b0);
    check("t2_idle", idle, 1'b1);

    // simultaneous store + load
    pkt_base = pkt_q.size();
    wr_en = 1'b1; wr_addr = 32'h1; wr_data = 32'hA5A50001;
    rd_en = 1'b1; rd_addr = 32'h2;
    tick();
    clear_reqs();
    wait_pkts(2, "t3_count");
    check("t3_first", get_pkt(0), {1'b1, 32'h1, 32'hA5A50001});
    check("t3_second", get_pkt(1), {1'b0, 32'h2, 32'h0});
    return_one(32'h55550003, "t3");

    // backpressure with three queued
    pkt_base = pkt_q.size();
    out_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'h100;
    rd_en = 1'b1; rd_addr = 32'h11;
    tick();
    clear_reqs();
    check("t4_ready_at2", req_ready, 1'b1);
    wr_en = 1'b1; wr_addr = 32'h12; wr_data = 32'h120;
    tick();
    clear_reqs();
    check("t4_ready_at3", req_ready, 1'b0);
    repeat (10) tick();
    check("t4_held", npk(), 0);
    check("t4_no_err", err, 1'b0);
    check("t4_outv", out_v, 1'b1);
    out_ready = 1'b1;
    wait_pkts(3, "t4_count");
    check("t4_p0", get_pkt(0), {1'b1, 32'h10, 32'h100});
    check("t4_p1", get_pkt(1), {1'b0, 32'h11, 32'h0});
    check("t4_p2", get_pkt(2), {1'b1, 32'h12, 32'h120});
    return_one(32'h0000BEEF, "t4");
    check("t4_idle", idle, 1'b1);

    // load limit
    pkt_base = pkt_q.size();
    rd_en = 1'b1; rd_addr = 32'h20; tick();
    rd_addr = 32'h21; tick();
    rd_addr = 32'h22; tick();
    clear_reqs();
    repeat (5) tick();
    check("t5_two_launched", npk(), 2);
    check("t5_third_held", out_v, 1'b0);
    return_one(32'h111, "t5a");
    wait_pkts(3, "t5_third");
    check("t5_third_pkt", get_pkt(2), {1'b0, 32'h22, 32'h0});
    return_one(32'h222, "t5b");
    return_one(32'h333, "t5c");
    check("t5_idle", idle, 1'b1);

    // zero credits hold a store
    pkt_base = pkt_q.size();
    credits = 5'd0;
    wr_en = 1'b1; wr_addr = 32'h30; wr_data = 32'h300;
    tick();
    clear_reqs();
    repeat (5) tick();
    check("t5_cred_hold", npk(), 0);
    check("t5_cred_outv", out_v, 1'b0);
    credits = 5'd1;
    wait_pkts(1, "t5_cred_go");
    check("t5_cred_pkt", get_pkt(0), {1'b1, 32'h30, 32'h300});
    credits = 5'd16;
    tick();

    // dropped request, mid-queue reset, unexpected return
    pkt_base = pkt_q.size();
    out_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 32'h40; wr_data = 32'h400;
    rd_en = 1'b1; rd_addr = 32'h41;
    tick();
    rd_en = 1'b0; wr_addr = 32'h42; wr_data = 32'h420;
    tick();
    check("t6_err_before_drop", err, 1'b0);
    wr_addr = 32'h43; wr_data = 32'h430;
    tick();
    clear_reqs();
    check("t6_drop_err", err, 1'b1);
    pulse_reset();
    check("t6_rst_err", err, 1'b0);
    check("t6_rst_idle", idle, 1'b1);
    check("t6_rst_outv", out_v, 1'b0);
    out_ready = 1'b1;
    repeat (3) tick();
    check("t6_rst_discard", npk(), 0);
    check("t6_rst_ready", req_ready, 1'b1);
    ret_v = 1'b1; ret_data = 32'h99;
    tick();
    ret_v = 1'b0;
    check("t6_bad_ret_rdv", rd_valid, 1'b0);
    check("t6_bad_ret_err", err, 1'b1);
    repeat (3) tick();
    check("t6_err_sticky", err, 1'b1);
    check("t6_idle", idle, 1'b1);

    // randomized traffic against the in-order model
    pulse_reset();
    tick();
    pkt_base = pkt_q.size();
    rd_base = rd_q.size();
    ld_base = ld_launch_m;
    rdc_base = rd_seen_m;
    scan = pkt_q.size();
    rnd_phase = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      while (scan < pkt_q.size()) begin
        if (!pkt_q[scan].we) due_q.push_back(cyc + $urandom_range(0, 6));
        scan++;
      end
      if (cyc >= 500 && npk() == exp_pkt.size() && due_q.size() == 0) break;
      ret_v = 1'b0;
      if (due_q.size() > 0 && cyc >= due_q[0]) begin
        ret_v = 1'b1;
        ret_data = $urandom;
        exp_rd.push_back(ret_data);
        void'(due_q.pop_front());
      end
      if (cyc >= 500) begin
        out_ready = 1'b1;
        credits = 5'd16;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
        credits = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 16));
      end
      clear_reqs();
      if (cyc < 500 && req_ready) begin
        r = $urandom_range(0, 3);
        if (r[0]) begin
          wr_en = 1'b1; wr_addr = $urandom; wr_data = $urandom;
          e = '{we: 1'b1, addr: wr_addr, data: wr_data};
          exp_pkt.push_back(e);
        end
        if (r[1]) begin
          rd_en = 1'b1; rd_addr = $urandom;
          e = '{we: 1'b0, addr: rd_addr, data: 32'h0};
          exp_pkt.push_back(e);
        end
      end
      tick();
    end
    ret_v = 1'b0;
    clear_reqs();
    repeat (3) tick();
    rnd_phase = 1'b0;
    check("rnd_pkt_count", npk(), exp_pkt.size());
    for (int i = 0; i < exp_pkt.size(); i++) check("rnd_pkt", get_pkt(i), exp_pkt[i]);
    check("rnd_rd_count", rd_q.size() - rd_base, exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++) begin
      if (rd_base + i < rd_q.size()) check("rnd_rd", rd_q[rd_base + i], exp_rd[i]);
      else check("rnd_rd_missing", 1'b0, 1'b1);
    end
    check("rules_viol", viol, 0);
    check("rnd_idle", idle, 1'b1);
    check("rnd_err", err, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
